// File: rtl/reaction_timer_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction_timer block.
//   rt_state_t      : round-control state encoding
//   LIGHTS_ALL_ON   : light-bus value with all eight lights lit
//   LIGHTS_ALL_OFF  : light-bus value with every light dark (lights-out)
// ---------------------------------------------------------------------------
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FOUL
  } rt_state_t;

  localparam logic [7:0] LIGHTS_ALL_ON  = 8'hFF;
  localparam logic [7:0] LIGHTS_ALL_OFF = 8'h00;

endpackage

// File: rtl/reaction_timer_if.sv
// ---------------------------------------------------------------------------
// reaction_timer_if
// Bundle between the start-lights / player side and the reaction timer.
//   lights       : 8-bit light bus, bit i = light i lit (sync to clk)
//   button       : raw player push-button, asynchronous, active-high
//   result_ms    : last measured reaction time in ms
//   result_valid : one-cycle pulse when result_ms updates
//   jump_start   : level, press seen before lights-out
//   timeout      : level, no press before the ms count saturated
//   busy         : high while a round is armed or timing
//   best_ms      : best valid reaction time (BEST_TIME_EN builds only)
// Modports: master = lights/player side, slave = reaction_timer.
// ---------------------------------------------------------------------------
interface reaction_timer_if #(
  parameter int CNT_W = 14
);
  logic [7:0]       lights;
  logic             button;
  logic [CNT_W-1:0] result_ms;
  logic             result_valid;
  logic             jump_start;
  logic             timeout;
  logic             busy;
  logic [CNT_W-1:0] best_ms;

  modport master (
    output lights, button,
    input  result_ms, result_valid, jump_start, timeout, busy, best_ms
  );

  modport slave (
    input  lights, button,
    output result_ms, result_valid, jump_start, timeout, busy, best_ms
  );
endinterface

// File: rtl/reaction_timer_ms_prescaler.sv
// ---------------------------------------------------------------------------
// ms_prescaler
// Divides clk down to a millisecond tick.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear of the divider count
//   en   : count enable
//   tick : one-cycle pulse on the last of every TICK_DIV enabled cycles
// ---------------------------------------------------------------------------
module ms_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/reaction_timer.sv
// ---------------------------------------------------------------------------
// reaction_timer
// Player-side receiver of the start-lights sequence. After the lights have
// all been lit and then all go dark, counts whole milliseconds until the
// player presses the button. Flags presses before lights-out (jump start)
// and rounds where the count saturates at MAX_MS (timeout).
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : reaction_timer_if.slave (lights/button in, results out)
// Optional build macro BEST_TIME_EN: keeps the minimum valid result on
// best_ms; without it best_ms is the constant MAX_MS.
// ---------------------------------------------------------------------------
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 14,
  parameter int MAX_MS   = 9999
) (
  input  logic            clk,
  input  logic            rst,
  reaction_timer_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_MS - 1);

  rt_state_t        state;
  logic             seen_full;
  logic [CNT_W-1:0] ms;
  logic             tick;
  logic             b_meta, b_sync, b_prev, press;
  logic             all_on, all_off, saturate;
  logic [CNT_W-1:0] result_ms;
  logic             result_valid, jump_start, timeout, busy;

  assign all_on   = (bus.lights == LIGHTS_ALL_ON);
  assign all_off  = (bus.lights == LIGHTS_ALL_OFF);
  // The tick that would take the count to MAX_MS ends the round.
  assign saturate = tick && (ms == MAX_M1);

  // NOTE: every clocked block uses non-blocking assignments so each flop
  // samples the pre-edge value of its neighbour; a blocking chain here would
  // collapse the synchroniser into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_meta <= 1'b0;
      b_sync <= 1'b0;
      b_prev <= 1'b0;
      press  <= 1'b0;
    end else begin
      b_meta <= bus.button;
      b_sync <= b_meta;
      b_prev <= b_sync;
      press  <= b_sync & ~b_prev;
    end
  end

  // Divider only runs in TIMING and is held at zero otherwise, so it always
  // starts from zero on entry.
  ms_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != TIMING),
    .en   (state == TIMING),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      seen_full    <= 1'b0;
      ms           <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE, DONE, FOUL: begin
          if (!all_off) begin
            state      <= ARMED;
            busy       <= 1'b1;
            seen_full  <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        ARMED: begin
          if (press) begin
            state      <= FOUL;
            jump_start <= 1'b1;
            busy       <= 1'b0;
          end else if (all_off) begin
            if (seen_full) begin
              state <= TIMING;
              ms    <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (all_on) begin
            seen_full <= 1'b1;
          end
        end
        TIMING: begin
          if (tick && ms != MAX_V) ms <= ms + 1'b1;
          if (saturate) begin
            state        <= DONE;
            result_ms    <= MAX_V;
            result_valid <= 1'b1;
            timeout      <= 1'b1;
            busy         <= 1'b0;
          end else if (press) begin
            state        <= DONE;
            result_ms    <= ms;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BEST_TIME_EN
  logic [CNT_W-1:0] best_ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      best_ms <= MAX_V;
    else if (result_valid && !timeout && (result_ms < best_ms))
      best_ms <= result_ms;
  end

  assign bus.best_ms = best_ms;
`else
  assign bus.best_ms = MAX_V;
`endif

  assign bus.result_ms    = result_ms;
  assign bus.result_valid = result_valid;
  assign bus.jump_start   = jump_start;
  assign bus.timeout      = timeout;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer
// Directed bench for reaction_timer with TICK_DIV=4, MAX_MS=20.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Timing reference: with lights=00 seen at edge P1 (entry to TIMING), the ms
// count is n after edge P(1+4n). A button set just after edge Pd reaches the
// FSM at edge P(d+4), so the result is floor((d+2)/4).
// ---------------------------------------------------------------------------
module tb_reaction_timer;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 14;
  localparam int MAX_MS   = 20;

  logic clk = 1'b0;
  logic rst;
  int   errors   = 0;
  int   checks   = 0;
  int   rv_count = 0;
  int   rv_snap;

  always #5 clk = ~clk;

  reaction_timer_if #(.CNT_W(CNT_W)) bus ();

  reaction_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .MAX_MS   (MAX_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Counts high cycles of result_valid; a one-cycle pulse adds exactly one.
  always @(posedge clk) if (bus.result_valid === 1'b1) rv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int best_exp(input int v);
`ifdef BEST_TIME_EN
    return v;
`else
    return MAX_MS;
`endif
  endfunction

  // Lights 01,03,...,FF one per cycle, then 00 set just after edge P0.
  task automatic lights_seq();
    logic [7:0] l;
    l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      l = {l[6:0], 1'b1};
      bus.lights = l;
      step();
    end
    bus.lights = 8'h00;
  endtask

  // d >= 0: press d cycles after lights-out; d < 0: no press (timeout).
  task automatic round(input int d, input int exp_ms, input bit exp_to, input int exp_best);
    lights_seq();
    if (d >= 0) begin
      repeat (d) step();
      check("busy_timing", bus.busy, 1);
      bus.button = 1'b1;
      repeat (3) step();
      check("rv_early", bus.result_valid, 0);
      step();
    end else begin
      repeat (80) step();
      check("rv_early", bus.result_valid, 0);
      step();
    end
    check("rv_pulse", bus.result_valid, 1);
    check("result_ms", bus.result_ms, exp_ms);
    check("timeout", bus.timeout, exp_to);
    check("busy_done", bus.busy, 0);
    step();
    check("rv_one_cycle", bus.result_valid, 0);
    check("best_ms", bus.best_ms, exp_best);
    repeat (3) step();
    bus.button = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bus.lights = 8'h00;
    bus.button = 1'b0;
    #12;
    check("rst_result_ms", bus.result_ms, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_jump", bus.jump_start, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_best", bus.best_ms, MAX_MS);
    rst = 1'b0;
    step();

    // Results 7, 5, then a timeout round.
    round(26, 7, 1'b0, best_exp(7));
    round(18, 5, 1'b0, best_exp(5));
    round(-1, MAX_MS, 1'b1, best_exp(5));

    // Press 16 cycles after lights-out -> 4 ms.
    round(16, 4, 1'b0, best_exp(4));
    check("rv_total", rv_count, 4);

    // Jump start: press while lights=0F; lights go dark in the press cycle.
    rv_snap = rv_count;
    bus.lights = 8'h01; step();
    check("busy_armed", bus.busy, 1);
    check("timeout_cleared", bus.timeout, 0);
    bus.lights = 8'h03; step();
    bus.lights = 8'h0F; step();
    bus.button = 1'b1;
    repeat (3) step();
    check("jump_not_yet", bus.jump_start, 0);
    bus.lights = 8'h00;
    step();
    check("jump_set", bus.jump_start, 1);
    check("jump_busy", bus.busy, 0);
    repeat (3) step();
    check("jump_held", bus.jump_start, 1);
    bus.lights = 8'h01;
    step();
    check("jump_cleared", bus.jump_start, 0);
    check("rearm_busy", bus.busy, 1);
    repeat (6) step();
    check("held_button_once", bus.jump_start, 0);
    bus.button = 1'b0;

    // Aborted sequence: no all-on before lights-out.
    bus.lights = 8'h03; step();
    bus.lights = 8'h00; step();
    check("abort_idle", bus.busy, 0);
    repeat (4) step();
    check("abort_no_result", rv_count, rv_snap);
    check("best_after_foul", bus.best_ms, best_exp(4));

    // Asynchronous reset in the middle of TIMING.
    lights_seq();
    repeat (10) step();
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("arst_result_ms", bus.result_ms, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_timeout", bus.timeout, 0);
    check("arst_jump", bus.jump_start, 0);
    check("arst_rv", bus.result_valid, 0);
    check("arst_best", bus.best_ms, MAX_MS);
    #1;
    rst = 1'b0;
    rv_snap = rv_count;
    step();
    bus.button = 1'b1;
    repeat (8) step();
    check("post_rst_no_result", rv_count, rv_snap);
    check("post_rst_busy", bus.busy, 0);
    bus.button = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
